// File: rtl/clock_pkg.sv
// Shared types, constants and BCD helper for the clock_set_ctrl timekeeping block.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    SET_SS = 2'd3
  } mode_e;

  localparam logic [1:0] BLINK_HH   = 2'b00;
  localparam logic [1:0] BLINK_MM   = 2'b01;
  localparam logic [1:0] BLINK_SS   = 2'b10;
  localparam logic [1:0] BLINK_NONE = 2'b11;

  localparam logic [7:0] HH_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  // Returns {next BCD value, carry}; carry is set when value wraps from max to 00.
  function automatic logic [8:0] bcd_inc_wrap(input logic [7:0] value, input logic [7:0] max);
    logic [8:0] res;
    if (value == max) begin
      res = {8'h00, 1'b1};
    end else if (value[3:0] == 4'd9) begin
      res = {value[7:4] + 4'd1, 4'd0, 1'b0};
    end else begin
      res = {value[7:4], value[3:0] + 4'd1, 1'b0};
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-level counter and one-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_q;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // NOTE: non-blocking assignments keep r_sync1/r_sync2 a genuine two-stage pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      r_press   <= r_level & ~r_level_q;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/clock_set_ctrl.sv
// Digital clock timekeeping and RUN/SET controller with BCD hh:mm:ss and blink outputs.
// Optional macro CLOCK_SET_AUTOREPEAT_EN adds hold-to-repeat on the increment button.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       blink_en,
  output logic [1:0] blink_sel,
  output logic       tick_1hz
);

  localparam int PRE_W      = $clog2(CLK_HZ);
  localparam int BLINK_HALF = CLK_HZ / 4;
  localparam int BLK_W      = $clog2(BLINK_HALF + 1);

  mode_e            r_state;
  mode_e            w_next_state;
  logic [1:0]       w_sel_nxt;
  logic             w_mode_press;
  logic             w_inc_press;
  logic             w_mode_level;
  logic             w_inc_level;
  logic             w_inc_evt;
  logic             w_tick;
  logic             w_blk_wrap;
  logic             w_phase_nxt;
  logic             w_unused;
  logic [PRE_W-1:0] r_presc;
  logic [BLK_W-1:0] r_blk_cnt;
  logic             r_phase;
  logic             r_tick;
  logic             r_blink_en;
  logic [1:0]       r_blink_sel;
  logic [7:0]       r_hh;
  logic [7:0]       r_mm;
  logic [7:0]       r_ss;
  logic [8:0]       w_hh_inc;
  logic [8:0]       w_mm_inc;
  logic [8:0]       w_ss_inc;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dbc_mode (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_mode),
    .o_level (w_mode_level),
    .o_press (w_mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dbc_inc (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_inc),
    .o_level (w_inc_level),
    .o_press (w_inc_press)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_next_state;
  end

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    if (w_mode_press) begin
      case (r_state)
        RUN:     w_next_state = SET_HH;
        SET_HH:  w_next_state = SET_MM;
        SET_MM:  w_next_state = SET_SS;
        default: w_next_state = RUN;
      endcase
    end
  end

  always_comb begin
    w_sel_nxt = BLINK_NONE;
    case (w_next_state)
      SET_HH:  w_sel_nxt = BLINK_HH;
      SET_MM:  w_sel_nxt = BLINK_MM;
      SET_SS:  w_sel_nxt = BLINK_SS;
      default: w_sel_nxt = BLINK_NONE;
    endcase
  end

  // Blink outputs follow the next state so they change on the same edge as r_state.
  assign w_blk_wrap  = (r_blk_cnt == BLK_W'(BLINK_HALF - 1));
  assign w_phase_nxt = r_phase ^ w_blk_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk_cnt   <= '0;
      r_phase     <= 1'b0;
      r_blink_en  <= 1'b0;
      r_blink_sel <= BLINK_NONE;
    end else begin
      r_blk_cnt   <= w_blk_wrap ? '0 : r_blk_cnt + BLK_W'(1);
      r_phase     <= w_phase_nxt;
      r_blink_en  <= w_phase_nxt & (w_next_state != RUN);
      r_blink_sel <= w_sel_nxt;
    end
  end

  assign w_tick = (r_state == RUN) && (r_presc == PRE_W'(CLK_HZ - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_tick;
      if (r_state != RUN || w_tick) r_presc <= '0;
      else                          r_presc <= r_presc + PRE_W'(1);
    end
  end

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int REP_FIRST = CLK_HZ / 2;
  localparam int REP_NEXT  = (CLK_HZ / 8 > 0) ? CLK_HZ / 8 : 1;
  localparam int REP_W     = $clog2(REP_FIRST + 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_armed;
  logic             r_rep_pulse;
  logic             w_rep_hit;

  assign w_rep_hit = r_rep_armed ? (r_rep_cnt == REP_W'(REP_NEXT - 1))
                                 : (r_rep_cnt == REP_W'(REP_FIRST - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
      r_rep_pulse <= 1'b0;
    end else if (r_state == RUN || !w_inc_level || w_next_state != r_state) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
      r_rep_pulse <= 1'b0;
    end else if (w_rep_hit) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b1;
      r_rep_pulse <= 1'b1;
    end else begin
      r_rep_cnt   <= r_rep_cnt + REP_W'(1);
      r_rep_pulse <= 1'b0;
    end
  end

  assign w_inc_evt = w_inc_press | r_rep_pulse;
`else
  assign w_inc_evt = w_inc_press;
`endif

  assign w_ss_inc = bcd_inc_wrap(r_ss, MS_MAX);
  assign w_mm_inc = bcd_inc_wrap(r_mm, MS_MAX);
  assign w_hh_inc = bcd_inc_wrap(r_hh, HH_MAX);

  // Ticks only occur in RUN, where set-mode increments are ignored; mode beats inc.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hh <= 8'h00;
      r_mm <= 8'h00;
      r_ss <= 8'h00;
    end else if (w_tick) begin
      r_ss <= w_ss_inc[8:1];
      if (w_ss_inc[0]) begin
        r_mm <= w_mm_inc[8:1];
        if (w_mm_inc[0]) r_hh <= w_hh_inc[8:1];
      end
    end else if (w_inc_evt && !w_mode_press) begin
      case (r_state)
        SET_HH:  r_hh <= w_hh_inc[8:1];
        SET_MM:  r_mm <= w_mm_inc[8:1];
        SET_SS:  r_ss <= w_ss_inc[8:1];
        default: ;
      endcase
    end
  end

  assign w_unused = ^{w_mode_level, w_inc_level, w_hh_inc[0]};

  assign hh        = r_hh;
  assign mm        = r_mm;
  assign ss        = r_ss;
  assign blink_en  = r_blink_en;
  assign blink_sel = r_blink_sel;
  assign tick_1hz  = r_tick;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: behavioural clock model plus directed and random buttons.
module tb_clock_set_ctrl;

  localparam int CLK_HZ = 8;
  localparam int DEB    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [7:0] hh, mm, ss;
  logic       blink_en;
  logic [1:0] blink_sel;
  logic       tick_1hz;

  int n_checks = 0;
  int n_errors = 0;

  clock_set_ctrl #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .blink_en  (blink_en),
    .blink_sel (blink_sel),
    .tick_1hz  (tick_1hz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: decimal fields, a run-cycle count for seconds, and
  // a button seen two edges late that must differ DEB times in a row.
  typedef struct {
    bit p1, p2, lvl, lvl_q, press;
    int run;
  } mbtn_t;

  mbtn_t m_bm, m_bi;
  bit    m_valid = 0;
  int    m_mode, m_h, m_m, m_s, m_run_cyc, m_cyc;
  bit    m_tick;

  function automatic mbtn_t btn_step(mbtn_t b, bit raw);
    mbtn_t n = b;
    bit    seen = b.p2;
    n.press = b.lvl && !b.lvl_q;
    n.lvl_q = b.lvl;
    n.p2    = b.p1;
    n.p1    = raw;
    if (seen != b.lvl) begin
      n.run = b.run + 1;
      if (n.run == DEB) begin
        n.lvl = seen;
        n.run = 0;
      end
    end else begin
      n.run = 0;
    end
    return n;
  endfunction

  function automatic mbtn_t btn_clear();
    mbtn_t b;
    b.p1 = 0; b.p2 = 0; b.lvl = 0; b.lvl_q = 0; b.press = 0; b.run = 0;
    return b;
  endfunction

  function automatic logic [7:0] to_bcd(int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int cur_field();
    case (m_mode)
      1:       return m_h;
      2:       return m_m;
      3:       return m_s;
      default: return -1;
    endcase
  endfunction

  task automatic model_step();
    bit mp, ip;
    if (rst) begin
      m_bm = btn_clear(); m_bi = btn_clear();
      m_mode = 0; m_h = 0; m_m = 0; m_s = 0;
      m_run_cyc = 0; m_cyc = 0; m_tick = 0;
      m_valid = 1;
    end else if (m_valid) begin
      mp = m_bm.press;
      ip = m_bi.press;
      m_bm = btn_step(m_bm, btn_mode);
      m_bi = btn_step(m_bi, btn_inc);
      m_tick = 0;
      if (m_mode == 0) begin
        m_run_cyc++;
        if (m_run_cyc % CLK_HZ == 0) begin
          m_tick = 1;
          m_s++;
          if (m_s == 60) begin
            m_s = 0; m_m++;
            if (m_m == 60) begin
              m_m = 0; m_h = (m_h + 1) % 24;
            end
          end
        end
      end else if (ip && !mp) begin
        case (m_mode)
          1: m_h = (m_h + 1) % 24;
          2: m_m = (m_m + 1) % 60;
          default: m_s = (m_s + 1) % 60;
        endcase
      end
      if (mp) m_mode = (m_mode + 1) % 4;
      if (m_mode != 0) m_run_cyc = 0;
      m_cyc++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Single compare process: all outputs against the model on every falling edge.
  initial forever begin
    logic [31:0] exp_v, act_v;
    logic [1:0]  exp_sel;
    bit          exp_en;
    @(negedge clk);
    if (m_valid) begin
      exp_sel = (m_mode == 0) ? 2'b11 : 2'(m_mode - 1);
      exp_en  = (((m_cyc / (CLK_HZ / 4)) % 2) == 1) && (m_mode != 0);
      exp_v = {4'h0, to_bcd(m_h), to_bcd(m_m), to_bcd(m_s), exp_en, exp_sel, m_tick};
      act_v = {4'h0, hh, mm, ss, blink_en, blink_sel, tick_1hz};
      check("model_cycle", act_v, exp_v);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic press(input bit pm, input bit pi);
    btn_mode = pm;
    btn_inc  = pi;
    repeat (8) @(negedge clk);
    btn_mode = 0;
    btn_inc  = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic inc_until(input int target);
    for (int i = 0; i < 64; i++) begin
      if (cur_field() == target) break;
      press(0, 1);
    end
  endtask

  initial begin
    int   ticks;
    logic e [6];

    // 1. Reset and free-running seconds
    repeat (3) @(negedge clk);
    check("reset_time", {8'h0, hh, mm, ss}, 32'h0);
    check("reset_flags", {28'h0, blink_en, blink_sel, tick_1hz}, 32'h6);
    rst = 0;
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tick_1hz) ticks++;
    end
    check("run_ss_40cyc", {24'h0, ss}, 32'h05);
    check("run_tick_count", ticks, 5);

    // 2. Debounce in SET_SS, plus blink
    repeat (3) press(1, 0);
    check("sel_set_ss", {30'h0, blink_sel}, 32'h2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e[i] = blink_en;
    end
    for (int i = 0; i < 4; i++) check("blink_toggle", {31'h0, e[i]}, {31'h0, ~e[i+2]});
    btn_inc = 1;
    repeat (2) @(negedge clk);
    btn_inc = 0;
    repeat (10) @(negedge clk);
    inc_until(30);
    btn_inc = 1;
    repeat (10) @(negedge clk);
    btn_inc = 0;
    repeat (10) @(negedge clk);
    check("inc_once_ss", {24'h0, ss}, 32'h31);

    // 3. Wrap in set mode, and 6. simultaneous press
    press(1, 0);
    press(1, 0);
    inc_until(23);
    press(0, 1);
    check("hh_wrap", {24'h0, hh}, 32'h00);
    inc_until(7);
    press(1, 1);
    check("simul_sel", {30'h0, blink_sel}, 32'h1);
    check("simul_hh", {24'h0, hh}, 32'h07);
    inc_until(59);
    press(0, 1);
    check("mm_wrap", {24'h0, mm}, 32'h00);
    check("mm_wrap_hh", {24'h0, hh}, 32'h07);

    // 4. Full rollover after returning to RUN
    press(1, 0);
    press(1, 0);
    press(1, 0);
    inc_until(23);
    press(1, 0);
    inc_until(59);
    press(1, 0);
    inc_until(59);
    btn_mode = 1;
    repeat (8) @(negedge clk);
    btn_mode = 0;
    repeat (7) @(negedge clk);
    check("pre_roll", {7'h0, hh, mm, ss, tick_1hz}, {7'h0, 24'h235959, 1'b0});
    @(negedge clk);
    check("rollover", {7'h0, hh, mm, ss, tick_1hz}, {7'h0, 24'h000000, 1'b1});
    check("run_blink", {29'h0, blink_en, blink_sel}, 32'h3);
    @(negedge clk);
    check("tick_one_cycle", {31'h0, tick_1hz}, 32'h0);

    // Random button activity with one mid-run reset
    for (int seg = 0; seg < 600; seg++) begin
      if (seg == 300) begin
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
      end
      btn_mode = ($urandom_range(0, 9) == 0);
      btn_inc  = ($urandom_range(0, 2) == 0);
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    btn_mode = 0;
    btn_inc  = 0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Timekeeping and time-setting controller for the digital clock.
- Produces the BCD hh/mm/ss fields and the blink controls consumed by the seven-segment scan driver.
- Accepts two raw push-buttons (mode, increment), debounces them, runs a RUN/SET state machine and counts seconds from the system clock.
- Sits between the board buttons and the display path.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency; must be a multiple of 4.
- DEBOUNCE_CYC, 1_000_000, consecutive stable cycles required to accept a button level change (20 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- btn_mode  in  1  raw mode button, active-high, asynchronous to clk
- btn_inc  in  1  raw increment button, active-high, asynchronous to clk
- hh  out  8  hours, BCD {tens, units}, 00..23
- mm  out  8  minutes, BCD, 00..59
- ss  out  8  seconds, BCD, 00..59
- blink_en  out  1  2 Hz blink phase, gated by set mode
- blink_sel  out  2  field being set: 00=HH, 01=MM, 10=SS, 11=none
- tick_1hz  out  1  one-cycle pulse per elapsed second in RUN

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- All outputs are registered.
- Reset values:
  - hh=mm=ss=8'h00.
  - State RUN; blink_sel=2'b11; blink_en=0; tick_1hz=0.
  - Prescaler, blink counter and debouncers cleared; debounced levels=0.
- Button input path:
  - Each button passes through a 2-FF synchroniser, then a debouncer.
  - Debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYC consecutive cycles.
  - Any revert to the old level restarts the count.
  - A debounced 0->1 transition produces a one-cycle press pulse on the following cycle.
  - Release produces no pulse.
- FSM states: RUN, SET_HH, SET_MM, SET_SS.
  - Mode press advances RUN->SET_HH->SET_MM->SET_SS->RUN.
  - Inc press in RUN is ignored.
- Set-mode increment:
  - Inc press in SET_x increments the selected field by 1, one cycle after the pulse.
  - HH wraps 23->00; MM and SS wrap 59->00.
  - No carry into other fields.
- Simultaneous mode and inc pulses in the same cycle: mode wins, inc is dropped.
- Timekeeping, RUN only:
  - Prescaler counts 0..CLK_HZ-1; at CLK_HZ-1 it wraps to 0 and tick_1hz pulses.
  - On tick: ss+1 (BCD). 59->00 carries to mm; mm 59->00 carries to hh; hh 23->00.
  - 23:59:59 rolls to 00:00:00 in a single cycle.
- Timekeeping in SET states: prescaler held at 0 and no ticks.
  - Returning to RUN restarts the prescaler from 0, so the first tick comes CLK_HZ cycles after entering RUN.
- BCD rule: units digit 9->0 increments tens; fields never hold non-BCD values.
- Blink:
  - Free-running counter toggles a phase bit every CLK_HZ/4 cycles, giving a 2 Hz square wave.
  - blink_en = phase AND (state != RUN).
  - blink_sel = 00/01/10 in SET_HH/SET_MM/SET_SS, 11 in RUN.
  - blink_sel updates in the same cycle as the state register.
- Reset mid-operation (including during debounce or in a SET state) returns to the reset values on the next edge.

Optional Feature:
- Macro: CLOCK_SET_AUTOREPEAT_EN.
- Defined:
  - In a SET state, holding inc debounced-high for CLK_HZ/2 cycles generates a repeat increment.
  - Further repeats follow every CLK_HZ/8 cycles until release; the same wrap rules apply.
  - The repeat counter resets on release or on any state change.
- Not defined: exactly one increment per press; no repeat logic is synthesised.

Decomposition:
- Package clock_pkg holds:
  - mode_e enum (RUN, SET_HH, SET_MM, SET_SS).
  - BLINK_HH/BLINK_MM/BLINK_SS/BLINK_NONE 2-bit constants.
  - HH_MAX=8'h23 and MS_MAX=8'h59.
  - A bcd_inc_wrap(value, max) function returning {wrapped value, carry}.
- Sub-module btn_debounce (synchroniser, stable counter and rising-edge pulse; parameter DEBOUNCE_CYC), instantiated twice.

Test Plan:
- Bench parameters: CLK_HZ=8, DEBOUNCE_CYC=4.
- 1. Reset: assert rst 3 cycles -> hh/mm/ss=00, blink_sel=11, blink_en=0, tick_1hz=0. Hold 40 cycles -> ss=8'h05, one tick per 8 cycles.
- 2. Debounce: btn_inc high 2 cycles then low while in SET_SS -> ss unchanged. High 10 cycles -> ss increments exactly once.
- 3. Wrap in set: mode to SET_MM, mm=8'h59, one inc press -> mm=8'h00, hh unchanged. In SET_HH from 8'h23 -> 8'h00.
- 4. Full rollover: set 23:59:59, cycle mode back to RUN -> after 8 cycles 00:00:00 with tick_1hz high for one cycle.
- 5. Blink: in SET_SS -> blink_sel=10 and blink_en toggles every 2 cycles. Back in RUN -> blink_en=0, blink_sel=11.
- 6. Simultaneous press: debounced mode and inc pulses in the same cycle while in SET_HH (hh=8'h07) -> state becomes SET_MM and hh stays 8'h07.
